axi_lite_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator. Converts a simple valid/ready command stream (one read or write per command) into AXI4-Lite transactions, and returns one response per command.
- Used by test sequencers, boot loaders and bridge logic to drive axi_lite slaves in this library, e.g. the GPIO controller.
- No bursts, no reordering, one transaction in flight.

---
 rtl/axi_lite_master_pkg.sv | 31 +++
 rtl/axi_lite_master.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_master_pkg
// Shared definitions for the single-outstanding AXI4-Lite initiator:
//   - AXI response codes (BRESP/RRESP encodings)
//   - master FSM state encodings
//   - width helper for the timeout counter
// -----------------------------------------------------------------------------
package axi_lite_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } master_state_e;

    // Counter must be able to hold the value TIMEOUT_CYCLES itself.
    function automatic int timeout_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
// Single-outstanding AXI4-Lite initiator. Accepts one read or write command on
// a valid/ready stream, runs the matching AXI4-Lite transaction and returns a
// single response. All outputs are registered.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   cmd_*                  command stream (write flag, addr, wdata, wstrb)
//   rsp_*                  response stream (write flag, rdata, resp)
//   m_axi_aw/w/b/ar/r*     AXI4-Lite master interface
//   busy                   high whenever the FSM is not in IDLE
//   timeout                sticky flag, set when a transaction waits on the
//                          slave for TIMEOUT_CYCLES cycles (0 disables)
// -----------------------------------------------------------------------------
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 4,
    parameter logic [2:0]  PROT           = 3'b000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  busy,
    output logic                  timeout
);

    localparam int            CW        = timeout_cnt_width(TIMEOUT_CYCLES);
    // With TIMEOUT_CYCLES=0 the limit is 0, so the counter never moves.
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    master_state_e         state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  busy_q, busy_d;
    logic                  timeout_q, timeout_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  waiting;
    logic                  aw_open;
    logic                  w_open;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;

        // Channels still waiting for their handshake after this cycle.
        aw_open = awvalid_q && !m_axi_awready;
        w_open  = wvalid_q  && !m_axi_wready;

        // Count only while the slave owes us something; RSP is our side.
        waiting = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_RESP);
        if (waiting && (cnt_q != CNT_LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
        if ((TIMEOUT_CYCLES != 0) && waiting && (cnt_d == CNT_LIMIT)) begin
            timeout_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    cnt_d       = '0;
                    timeout_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in either order.
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (!aw_open && !w_open) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                // Unreachable encodings fall back to a clean idle.
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = PROT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = PROT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
// Directed bench for axi_lite_master. Commands push their expected response
// into a queue; an independent monitor pops and compares on every response
// handshake. A small behavioural AXI4-Lite slave (4-word memory, configurable
// ready delays, response codes and stalls) sits on the master port.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;
    import axi_lite_master_pkg::*;

    localparam int AW = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]    m_axi_awprot, m_axi_arprot;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0]   m_axi_wdata, m_axi_rdata;
    logic [3:0]    m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;
    logic          busy, timeout;

    axi_lite_master #(.ADDR_WIDTH(AW), .PROT(3'b000), .TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .busy(busy), .timeout(timeout)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   rsp_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: one response per handshake.
    always @(negedge aclk) begin
        if (aresetn && rsp_valid && rsp_ready) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=write:%0d rdata:%h resp:%b required=none",
                         rsp_write, rsp_rdata, rsp_resp);
            end else begin
                mon_e = exp_q.pop_front();
                $display("RSP write=%0d rdata=%h resp=%b", rsp_write, rsp_rdata, rsp_resp);
                chk("rsp_write", 32'(rsp_write), 32'(mon_e.write));
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_resp", 32'(rsp_resp), 32'(mon_e.resp));
            end
        end
    end

    // Write-channel protocol observer.
    int            aw_hi = 0, w_hi = 0, b_early = 0, aw_unstable = 0;
    logic          aw_prev_valid = 1'b0;
    logic [AW-1:0] aw_prev_addr = '0;
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_axi_awvalid) aw_hi++;
            if (m_axi_wvalid)  w_hi++;
            if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) b_early++;
            if (m_axi_awvalid && aw_prev_valid && (m_axi_awaddr != aw_prev_addr)) aw_unstable++;
            aw_prev_valid = m_axi_awvalid;
            aw_prev_addr  = m_axi_awaddr;
        end
    end

    // Behavioural slave, evaluated on the falling edge so its inputs to the
    // DUT are stable for the following rising edge.
    logic [31:0]   mem [4];
    int            aw_delay = 0, aw_cnt = 0;
    bit            ar_hang = 0, b_hold = 0, r_force = 0;
    logic [1:0]    bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
    logic [31:0]   r_force_data = '0;
    bit            aw_have = 0, w_have = 0, ar_have = 0, b_fire = 0, r_fire = 0;
    logic [AW-1:0] aw_addr_s, ar_addr_s;
    logic [31:0]   w_data_s;
    logic [3:0]    w_strb_s;

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                aw_have = 0; w_have = 0; ar_have = 0; b_fire = 0; r_fire = 0; aw_cnt = 0;
            end else begin
                if (b_fire) begin
                    m_axi_bvalid = 0;
                    b_fire = 0;
                end else begin
                    if (!m_axi_bvalid && aw_have && w_have && !b_hold) begin
                        if (bresp_cfg == RESP_OKAY)
                            for (int i = 0; i < 4; i++)
                                if (w_strb_s[i]) mem[aw_addr_s[3:2]][8*i +: 8] = w_data_s[8*i +: 8];
                        m_axi_bresp  = bresp_cfg;
                        m_axi_bvalid = 1;
                        aw_have = 0;
                        w_have  = 0;
                    end
                    if (m_axi_bvalid && m_axi_bready) b_fire = 1;
                end
                if (r_fire) begin
                    m_axi_rvalid = 0;
                    r_fire = 0;
                end else begin
                    if (!m_axi_rvalid && ar_have) begin
                        m_axi_rdata  = r_force ? r_force_data : mem[ar_addr_s[3:2]];
                        m_axi_rresp  = rresp_cfg;
                        m_axi_rvalid = 1;
                        ar_have = 0;
                    end
                    if (m_axi_rvalid && m_axi_rready) r_fire = 1;
                end
                if (m_axi_awready) m_axi_awready = 0;
                else if (m_axi_awvalid) begin
                    if (aw_cnt >= aw_delay) begin
                        m_axi_awready = 1; aw_have = 1; aw_addr_s = m_axi_awaddr; aw_cnt = 0;
                    end else aw_cnt++;
                end
                if (m_axi_wready) m_axi_wready = 0;
                else if (m_axi_wvalid) begin
                    m_axi_wready = 1; w_have = 1; w_data_s = m_axi_wdata; w_strb_s = m_axi_wstrb;
                end
                if (m_axi_arready) m_axi_arready = 0;
                else if (m_axi_arvalid && !ar_hang) begin
                    m_axi_arready = 1; ar_have = 1; ar_addr_s = m_axi_araddr;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic [1:0] eresp);
        int n;
        n = 0;
        @(negedge aclk);
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_wait actual=0 required=1 within 50 cycles");
            return;
        end
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        exp_q.push_back('{wr, er, eresp});
        $display("CMD write=%0d addr=%h wdata=%h wstrb=%h", wr, a, d, s);
        @(posedge aclk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_done actual=%0d_pending required=0_pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    int c0;
    int n;

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1;
        aresetn = 0;
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_awvalid", 32'(m_axi_awvalid), 0);
        chk("rst_wvalid", 32'(m_axi_wvalid), 0);
        chk("rst_arvalid", 32'(m_axi_arvalid), 0);
        chk("rst_bready", 32'(m_axi_bready), 0);
        chk("rst_rready", 32'(m_axi_rready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_awaddr", 32'(m_axi_awaddr), 0);
        @(posedge aclk); #1;
        aresetn = 1;
        repeat (2) @(posedge aclk);

        // 1: basic write then read-back
        issue(1, 4'h4, 32'h0000_00FF, 4'hF, 32'h0, RESP_OKAY);
        wait_done("t1_wr");
        issue(0, 4'h4, 32'h0, 4'h0, 32'h0000_00FF, RESP_OKAY);
        wait_done("t1_rd");

        // 2: AWREADY late by two extra cycles, WREADY immediate
        @(posedge aclk); #1;
        aw_delay = 2; aw_hi = 0; w_hi = 0; b_early = 0; aw_unstable = 0; c0 = rsp_count;
        issue(1, 4'hC, 32'h1234_5678, 4'hF, 32'h0, RESP_OKAY);
        wait_done("t2_wr");
        chk("t2_awvalid_cycles", aw_hi, 3);
        chk("t2_wvalid_cycles", w_hi, 1);
        chk("t2_bready_early", b_early, 0);
        chk("t2_awaddr_unstable", aw_unstable, 0);
        chk("t2_rsp_count", rsp_count - c0, 1);
        @(posedge aclk); #1;
        aw_delay = 0;

        // 3: error responses passed through, no retry
        bresp_cfg = RESP_SLVERR;
        issue(1, 4'h8, 32'hCAFE_F00D, 4'hF, 32'h0, RESP_SLVERR);
        wait_done("t3_wr");
        @(posedge aclk); #1;
        bresp_cfg = RESP_OKAY; rresp_cfg = RESP_DECERR;
        issue(0, 4'h8, 32'h0, 4'h0, 32'h0, RESP_DECERR);
        wait_done("t3_rd");
        @(posedge aclk); #1;
        rresp_cfg = RESP_OKAY;
        issue(0, 4'hC, 32'h0, 4'h0, 32'h1234_5678, RESP_OKAY);
        wait_done("t3_rd2");

        // 4: response back-pressure
        @(posedge aclk); #1;
        r_force = 1; r_force_data = 32'hDEAD_BEEF; rsp_ready = 0;
        issue(0, 4'h4, 32'h0, 4'h0, 32'hDEAD_BEEF, RESP_OKAY);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("t4_rsp_valid_seen", 32'(rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("t4_rsp_valid_hold", 32'(rsp_valid), 1);
            chk("t4_rsp_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
            chk("t4_cmd_ready_low", 32'(cmd_ready), 0);
        end
        @(posedge aclk); #1;
        rsp_ready = 1;
        @(negedge aclk);
        chk("t4_cmd_ready_pre", 32'(cmd_ready), 0);
        @(negedge aclk);
        chk("t4_cmd_ready_post", 32'(cmd_ready), 1);
        chk("t4_rsp_valid_post", 32'(rsp_valid), 0);
        wait_done("t4_rd");
        @(posedge aclk); #1;
        r_force = 0;

        // 5: timeout with a stalled ARREADY (TIMEOUT_CYCLES=8)
        ar_hang = 1;
        issue(0, 4'h4, 32'h0, 4'h0, 32'h0000_00FF, RESP_OKAY);
        repeat (7) @(posedge aclk);
        @(negedge aclk);
        chk("t5_timeout_before", 32'(timeout), 0);
        @(posedge aclk);
        @(negedge aclk);
        chk("t5_timeout_set", 32'(timeout), 1);
        chk("t5_arvalid_held", 32'(m_axi_arvalid), 1);
        repeat (3) @(posedge aclk);
        #1;
        ar_hang = 0;
        wait_done("t5_rd");
        chk("t5_timeout_sticky", 32'(timeout), 1);
        issue(1, 4'h0, 32'hA5A5_A5A5, 4'hF, 32'h0, RESP_OKAY);
        @(negedge aclk);
        chk("t5_timeout_cleared", 32'(timeout), 0);
        wait_done("t5_wr");

        // 6: reset during WR_RESP
        @(posedge aclk); #1;
        b_hold = 1;
        issue(1, 4'h4, 32'h1111_1111, 4'hF, 32'h0, RESP_OKAY);
        n = 0;
        while (!m_axi_bready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("t6_bready_seen", 32'(m_axi_bready), 1);
        #2;
        aresetn = 0;
        #1;
        chk("t6_bready_async", 32'(m_axi_bready), 0);
        chk("t6_busy_async", 32'(busy), 0);
        chk("t6_rsp_valid_async", 32'(rsp_valid), 0);
        chk("t6_cmd_ready_async", 32'(cmd_ready), 1);
        exp_q.delete();
        c0 = rsp_count;
        @(negedge aclk);
        @(posedge aclk); #1;
        b_hold = 0;
        aresetn = 1;
        repeat (3) @(negedge aclk);
        chk("t6_no_response", rsp_count - c0, 0);
        chk("t6_cmd_ready_after", 32'(cmd_ready), 1);
        issue(0, 4'h0, 32'h0, 4'h0, 32'hA5A5_A5A5, RESP_OKAY);
        wait_done("t6_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
